// File: rtl/seven_seg_pkg.sv
// Shared definitions for the four-digit seven-segment scanner.
//   NUM_DIGITS       : number of multiplexed digits
//   state_t          : scan FSM states (IDLE, SHOW, GUARD)
//   AN_BLANK/SEG_BLANK: all-off patterns for the active-low pins
//   hex_to_seg()     : hex nibble -> active-low segments, bit 0 = a .. bit 6 = g
package seven_seg_pkg;

   localparam int NUM_DIGITS = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_GUARD = 2'd2
   } state_t;

   localparam logic [3:0] AN_BLANK  = 4'hF;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'h40;
         4'h1:    s = 7'h79;
         4'h2:    s = 7'h24;
         4'h3:    s = 7'h30;
         4'h4:    s = 7'h19;
         4'h5:    s = 7'h12;
         4'h6:    s = 7'h02;
         4'h7:    s = 7'h78;
         4'h8:    s = 7'h00;
         4'h9:    s = 7'h10;
         4'hA:    s = 7'h08;
         4'hB:    s = 7'h03;
         4'hC:    s = 7'h46;
         4'hD:    s = 7'h21;
         4'hE:    s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex-to-segment decoder.
//   nibble : hex digit to display
//   seg_n  : active-low segments, [0]=a .. [6]=g
module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = hex_to_seg(nibble);
   end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit multiplexed seven-segment scanner with anti-ghosting gaps.
// Each digit is lit for div_reload+1 cycles (SHOW), followed by GUARD_CYCLES
// cycles with every anode off (GUARD). Configuration is double-buffered:
// cfg_valid loads a pending set, which becomes active only when leaving IDLE
// or at the digit3->digit0 wrap, so a frame never mixes old and new values.
// Ports:
//   ACLK, ARESET            : clock, synchronous active-high reset
//   enable                  : scanning runs while high
//   cfg_valid               : one-cycle strobe capturing the cfg inputs
//   digit_data/dp_mask/blank_mask/div_reload : configuration inputs
//   an_n, seg_n, dp_n       : registered active-low display pins
//   frame_tick              : one-cycle pulse at each 3->0 wrap
//   state_dbg               : current FSM state, for observation
module seven_seg_scan
   import seven_seg_pkg::*;
#(
   parameter int GUARD_CYCLES = 2,
   parameter int DIV_W        = 16
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             enable,
   input  logic             cfg_valid,
   input  logic [15:0]      digit_data,
   input  logic [3:0]       dp_mask,
   input  logic [3:0]       blank_mask,
   input  logic [DIV_W-1:0] div_reload,
   output logic [3:0]       an_n,
   output logic [6:0]       seg_n,
   output logic             dp_n,
   output logic             frame_tick,
   output state_t           state_dbg
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int GW    = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
   localparam int CNT_W = (DIV_W > GW) ? DIV_W : GW;
   localparam logic [CNT_W-1:0] GUARD_LAST =
      (GUARD_CYCLES > 0) ? CNT_W'(GUARD_CYCLES - 1) : '0;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [15:0]        pend_data_q, pend_data_d, act_data_q, act_data_d;
   logic [3:0]         pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
   logic [3:0]         pend_blank_q, pend_blank_d, act_blank_q, act_blank_d;
   logic [DIV_W-1:0]   pend_div_q, pend_div_d, act_div_q, act_div_d;

   logic [3:0]         an_n_q, an_n_d;
   logic [6:0]         seg_n_q, seg_n_d;
   logic               dp_n_q, dp_n_d;
   logic               tick_q, tick_d;

   logic               commit;
   logic               wrap;
   logic [3:0]         act_nibble;
   logic [6:0]         dec_seg_n;

   assign act_nibble = act_data_q[{idx_q, 2'b00} +: 4];

   seven_seg_hex_decode u_dec (
      .nibble (act_nibble),
      .seg_n  (dec_seg_n)
   );

   // Scan FSM: next state, slot index and shared cycle counter.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      wrap    = 1'b0;
      commit  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SHOW;
               idx_d   = '0;
               cnt_d   = '0;
               commit  = 1'b1;
            end
            ST_SHOW: begin
               if (cnt_q == CNT_W'(act_div_q)) begin
                  cnt_d = '0;
                  if (GUARD_CYCLES == 0) begin
                     // No gap: step straight to the next digit slot.
                     idx_d = idx_q + 1'b1;
                     wrap  = (idx_q == IDX_LAST);
                  end else begin
                     state_d = ST_GUARD;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_GUARD: begin
               if (cnt_q == GUARD_LAST) begin
                  cnt_d   = '0;
                  idx_d   = idx_q + 1'b1;
                  wrap    = (idx_q == IDX_LAST);
                  state_d = ST_SHOW;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
         commit = commit | wrap;
      end
   end

   // Double-buffered config. Active loads from pending_d, so a cfg_valid in
   // the commit cycle lands in the active set at once.
   always_comb begin
      pend_data_d  = pend_data_q;
      pend_dp_d    = pend_dp_q;
      pend_blank_d = pend_blank_q;
      pend_div_d   = pend_div_q;
      if (cfg_valid) begin
         pend_data_d  = digit_data;
         pend_dp_d    = dp_mask;
         pend_blank_d = blank_mask;
         pend_div_d   = div_reload;
      end
      act_data_d  = act_data_q;
      act_dp_d    = act_dp_q;
      act_blank_d = act_blank_q;
      act_div_d   = act_div_q;
      if (commit) begin
         act_data_d  = pend_data_d;
         act_dp_d    = pend_dp_d;
         act_blank_d = pend_blank_d;
         act_div_d   = pend_div_d;
      end
   end

   // Pin values derived from the current state; registered below.
   always_comb begin
      an_n_d  = AN_BLANK;
      seg_n_d = SEG_BLANK;
      dp_n_d  = 1'b1;
      tick_d  = wrap;
      if (state_q == ST_SHOW && !act_blank_q[idx_q]) begin
         an_n_d  = ~(4'b0001 << idx_q);
         seg_n_d = dec_seg_n;
         dp_n_d  = ~act_dp_q[idx_q];
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q      <= ST_IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         pend_data_q  <= '0;
         pend_dp_q    <= '0;
         pend_blank_q <= '0;
         pend_div_q   <= '0;
         act_data_q   <= '0;
         act_dp_q     <= '0;
         act_blank_q  <= '0;
         act_div_q    <= '0;
         an_n_q       <= AN_BLANK;
         seg_n_q      <= SEG_BLANK;
         dp_n_q       <= 1'b1;
         tick_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         pend_data_q  <= pend_data_d;
         pend_dp_q    <= pend_dp_d;
         pend_blank_q <= pend_blank_d;
         pend_div_q   <= pend_div_d;
         act_data_q   <= act_data_d;
         act_dp_q     <= act_dp_d;
         act_blank_q  <= act_blank_d;
         act_div_q    <= act_div_d;
         an_n_q       <= an_n_d;
         seg_n_q      <= seg_n_d;
         dp_n_q       <= dp_n_d;
         tick_q       <= tick_d;
      end
   end

   assign an_n       = an_n_q;
   assign seg_n      = seg_n_q;
   assign dp_n       = dp_n_q;
   assign frame_tick = tick_q;
   assign state_dbg  = state_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Bench for seven_seg_scan: one instance with GUARD_CYCLES=2 and one with
// GUARD_CYCLES=0 share the stimulus. A position-in-frame model predicts the
// pins of both every cycle.
module tb_seven_seg_scan;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        enable;
   logic        cfg_valid;
   logic [15:0] digit_data;
   logic [3:0]  dp_mask;
   logic [3:0]  blank_mask;
   logic [15:0] div_reload;

   logic [3:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;
   logic        dp_a, dp_b;
   logic        tick_a, tick_b;
   seven_seg_pkg::state_t st_a, st_b;

   int checks   = 0;
   int failures = 0;

   always #5 ACLK = ~ACLK;

   seven_seg_scan #(.GUARD_CYCLES(2), .DIV_W(16)) u_dut_g2 (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .cfg_valid(cfg_valid),
      .digit_data(digit_data), .dp_mask(dp_mask), .blank_mask(blank_mask),
      .div_reload(div_reload), .an_n(an_a), .seg_n(seg_a), .dp_n(dp_a),
      .frame_tick(tick_a), .state_dbg(st_a)
   );

   seven_seg_scan #(.GUARD_CYCLES(0), .DIV_W(16)) u_dut_g0 (
      .ACLK(ACLK), .ARESET(ARESET), .enable(enable), .cfg_valid(cfg_valid),
      .digit_data(digit_data), .dp_mask(dp_mask), .blank_mask(blank_mask),
      .div_reload(div_reload), .an_n(an_b), .seg_n(seg_b), .dp_n(dp_b),
      .frame_tick(tick_b), .state_dbg(st_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   typedef struct {
      bit          run;
      int          pos;     // cycle position inside the current frame
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  blank;
      int          div;
   } mst_t;

   mst_t        m [2];
   int          gcyc [2] = '{2, 0};
   logic [15:0] p_data;
   logic [3:0]  p_dp, p_blank;
   int          p_div;
   logic [12:0] exp_pins [2];

   function automatic logic [11:0] disp(input mst_t s, input int g);
      int sl, d, off;
      logic [3:0] an;
      logic [3:0] nib;
      if (!s.run) return {4'hF, 7'h7F, 1'b1};
      sl  = s.div + 1 + g;
      d   = s.pos / sl;
      off = s.pos % sl;
      if (off > s.div || s.blank[d]) return {4'hF, 7'h7F, 1'b1};
      an  = 4'hF;
      an[d] = 1'b0;
      nib = s.data[d*4 +: 4];
      return {an, seg_tab[nib], ~s.dp[d]};
   endfunction

   task automatic model_edge();
      logic [15:0] n_data;
      logic [3:0]  n_dp, n_blank;
      int          n_div;
      logic [11:0] pins;
      bit          tick;
      n_data  = cfg_valid ? digit_data : p_data;
      n_dp    = cfg_valid ? dp_mask : p_dp;
      n_blank = cfg_valid ? blank_mask : p_blank;
      n_div   = cfg_valid ? int'(div_reload) : p_div;
      for (int k = 0; k < 2; k++) begin
         if (ARESET) begin
            m[k] = '{run: 0, pos: 0, data: '0, dp: '0, blank: '0, div: 0};
            exp_pins[k] = {4'hF, 7'h7F, 1'b1, 1'b0};
         end else begin
            tick = 0;
            pins = disp(m[k], gcyc[k]);
            if (!enable) begin
               m[k].run = 0;
               m[k].pos = 0;
            end else begin
               if (!m[k].run) begin
                  m[k].run = 1;
                  m[k].pos = 0;
                  tick = 0;
               end else begin
                  m[k].pos++;
                  if (m[k].pos == 4 * (m[k].div + 1 + gcyc[k])) begin
                     m[k].pos = 0;
                     tick = 1;
                  end
               end
               if (m[k].pos == 0) begin
                  m[k].data = n_data; m[k].dp = n_dp;
                  m[k].blank = n_blank; m[k].div = n_div;
               end
            end
            exp_pins[k] = {pins, tick};
         end
      end
      if (ARESET) begin
         p_data = '0; p_dp = '0; p_blank = '0; p_div = 0;
      end else begin
         p_data = n_data; p_dp = n_dp; p_blank = n_blank; p_div = n_div;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge ACLK);
      model_edge();
      #1;
      check("pins_g2", {19'd0, an_a, seg_a, dp_a, tick_a}, {19'd0, exp_pins[0]});
      check("pins_g0", {19'd0, an_b, seg_b, dp_b, tick_b}, {19'd0, exp_pins[1]});
   endtask

   task automatic run(input int n);
      repeat (n) cyc();
   endtask

   task automatic set_cfg(input logic [15:0] d, input logic [3:0] dp,
                          input logic [3:0] bl, input int dv);
      digit_data = d; dp_mask = dp; blank_mask = bl; div_reload = 16'(dv);
      cfg_valid = 1'b1;
      cyc();
      cfg_valid = 1'b0;
   endtask

   // Step until an_a equals want, at most limit cycles; flags a timeout.
   task automatic wait_an(input logic [3:0] want, input int limit, input string tag);
      int n = 0;
      while (an_a !== want && n < limit) begin
         cyc();
         n++;
      end
      check(tag, {31'd0, an_a === want}, 32'd1);
   endtask

   initial begin
      int last;
      ARESET = 1'b1; enable = 1'b0; cfg_valid = 1'b0;
      digit_data = '0; dp_mask = '0; blank_mask = '0; div_reload = '0;
      p_data = '0; p_dp = '0; p_blank = '0; p_div = 0;
      for (int k = 0; k < 2; k++) m[k] = '{run: 0, pos: 0, data: '0, dp: '0, blank: '0, div: 0};

      // reset state
      run(3);
      check("rst_state_g2", {30'd0, st_a}, {30'd0, seven_seg_pkg::ST_IDLE});
      check("rst_state_g0", {30'd0, st_b}, {30'd0, seven_seg_pkg::ST_IDLE});
      check("rst_pins", {19'd0, an_a, seg_a, dp_a, tick_a}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});

      // enable with no cfg: digit0 shows zero
      ARESET = 1'b0; enable = 1'b1;
      wait_an(4'hE, 10, "d0_seen");
      check("d0_seg", {25'd0, seg_a}, 32'h40);
      run(15);

      // reset mid-SHOW
      wait_an(4'hD, 20, "mid_show_seen");
      ARESET = 1'b1;
      cyc();
      check("rst_mid_show", {19'd0, an_a, seg_a, dp_a, tick_a}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
      ARESET = 1'b0;
      wait_an(4'hE, 10, "d0_after_rst");
      check("d0_seg_after_rst", {25'd0, seg_a}, 32'h40);

      // 1234, div 3, fresh from IDLE
      enable = 1'b0;
      set_cfg(16'h1234, 4'b0000, 4'b0000, 3);
      enable = 1'b1;
      last = -1;
      for (int i = 0; i < 80; i++) begin
         cyc();
         if (tick_a) begin
            if (last >= 0) check("tick_period_g2", i - last, 24);
            last = i;
         end
      end

      // blank slot 2, dp on slot 0 (committed at next wrap)
      set_cfg(16'h1234, 4'b0001, 4'b0100, 3);
      run(60);

      // two mid-frame updates: only the last one takes effect at the wrap
      run(7);
      set_cfg(16'h5555, 4'b0000, 4'b0000, 1);
      run(3);
      set_cfg(16'hABCD, 4'b0000, 4'b0000, 3);
      run(60);

      // drop enable during the gap after digit 2, then resume at digit 0
      wait_an(4'hB, 40, "d2_seen");
      wait_an(4'hF, 10, "d2_gap_seen");
      enable = 1'b0;
      set_cfg(16'h9876, 4'b1000, 4'b0000, 2);
      cyc();
      check("idle_after_drop", {30'd0, st_a}, {30'd0, seven_seg_pkg::ST_IDLE});
      run(2);
      enable = 1'b1;
      run(45);

      // fastest scan
      set_cfg(16'h0F5A, 4'b0010, 4'b0000, 0);
      last = -1;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (tick_b) begin
            if (last >= 0) check("tick_period_g0", i - last, 4);
            last = i;
         end
      end

      // cfg_valid coincident with leaving IDLE bypasses into the active set
      enable = 1'b0;
      cyc();
      enable = 1'b1;
      set_cfg(16'hC3E7, 4'b0100, 4'b0001, 1);
      run(20);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         ARESET     = ($urandom_range(0, 199) == 0);
         enable     = ($urandom_range(0, 39) != 0);
         cfg_valid  = ($urandom_range(0, 11) == 0);
         digit_data = 16'($urandom);
         dp_mask    = 4'($urandom_range(0, 15));
         blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
         div_reload = 16'($urandom_range(0, 3));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
